// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter onto a single registered IO bus.
// Optional access timeout enabled by defining IO_BUS_ARBITER_TIMEOUT_EN.
module io_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        m0_req,
   input  logic [15:0] m0_address,
   input  logic        m0_rw,
   input  logic [1:0]  m0_byte_enable,
   input  logic [15:0] m0_write_data,
   output logic [15:0] m0_read_data,
   output logic        m0_done,
   output logic        m0_error,
   input  logic        m1_req,
   input  logic [15:0] m1_address,
   input  logic        m1_rw,
   input  logic [1:0]  m1_byte_enable,
   input  logic [15:0] m1_write_data,
   output logic [15:0] m1_read_data,
   output logic        m1_done,
   output logic        m1_error,
   output logic [15:0] io_address,
   output logic [1:0]  io_byte_enable,
   output logic        io_rw,
   output logic [15:0] io_write_data,
   output logic        io_bus_enable,
   input  logic [15:0] io_read_data,
   input  logic        io_acknowledge
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

   state_t state;
   logic   grant;
   logic   last_grant;
   logic   pick;

   // Contention goes to the master not served last; otherwise whoever asks.
   assign pick = (m0_req && m1_req) ? ~last_grant : m1_req;

`ifdef IO_BUS_ARBITER_TIMEOUT_EN
   logic [15:0] timeout_cnt;
   logic        timeout_hit;

   assign timeout_hit = ({1'b0, timeout_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES);
`else
   assign m0_error = 1'b0;
   assign m1_error = 1'b0;
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state          <= StIdle;
         grant          <= 1'b0;
         last_grant     <= 1'b1;
         io_bus_enable  <= 1'b0;
         io_address     <= '0;
         io_byte_enable <= '0;
         io_rw          <= 1'b1;
         io_write_data  <= '0;
         m0_done        <= 1'b0;
         m1_done        <= 1'b0;
         m0_read_data   <= '0;
         m1_read_data   <= '0;
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
         m0_error       <= 1'b0;
         m1_error       <= 1'b0;
         timeout_cnt    <= '0;
`endif
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
         m0_error <= 1'b0;
         m1_error <= 1'b0;
`endif
         unique case (state)
            StIdle: begin
               if (m0_req || m1_req) begin
                  grant          <= pick;
                  last_grant     <= pick;
                  io_address     <= pick ? m1_address : m0_address;
                  io_byte_enable <= pick ? m1_byte_enable : m0_byte_enable;
                  io_rw          <= pick ? m1_rw : m0_rw;
                  io_write_data  <= pick ? m1_write_data : m0_write_data;
                  io_bus_enable  <= 1'b1;
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
                  timeout_cnt    <= '0;
`endif
                  state          <= StAccess;
               end
            end
            StAccess: begin
               if (io_acknowledge) begin
                  if (io_rw && !grant) m0_read_data <= io_read_data;
                  if (io_rw && grant) m1_read_data <= io_read_data;
                  m0_done       <= ~grant;
                  m1_done       <= grant;
                  io_bus_enable <= 1'b0;
                  state         <= StDone;
               end
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
               else if (timeout_hit) begin
                  m0_done       <= ~grant;
                  m1_done       <= grant;
                  m0_error      <= ~grant;
                  m1_error      <= grant;
                  io_bus_enable <= 1'b0;
                  state         <= StDone;
               end else begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
`endif
            end
            StDone: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, cycles in WAIT_ACK before abort (1..65535).
REQ-002 clk_clk  input  1  sole clock; all state on rising edge.
REQ-003 reset_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 mN_req  input  1  (N=0,1) master N requests one transfer; held high until mN_done.
REQ-005 mN_address  input  16  transfer address; mN_rw input 1 (1=read, 0=write); mN_byte_enable input 2; mN_write_data input 16.
REQ-006 mN_read_data  output  16  read data, valid when mN_done=1.
REQ-007 mN_done  output  1  one-cycle completion pulse; mN_error output 1, valid with mN_done, 1=timeout.
REQ-008 io_address  output  16; io_byte_enable output 2; io_rw output 1; io_write_data output 16: shared IO bus, registered.
REQ-009 io_bus_enable  output  1  transfer strobe, registered.
REQ-010 io_read_data  input  16; io_acknowledge input 1: slave response.

Function
REQ-011 States: IDLE, ACCESS, DONE.
REQ-012 IDLE: no request -> stay; any mN_req=1 -> grant one master, latch its address/rw/byte_enable/write_data onto io_* outputs, assert io_bus_enable next cycle, go ACCESS.
REQ-013 Arbitration round-robin: both requesting -> grant master not granted last; after reset m0 has priority.
REQ-014 ACCESS: io_bus_enable=1, io_* outputs stable; io_acknowledge=1 -> capture io_read_data into granted mN_read_data (reads only; writes leave it unchanged), deassert io_bus_enable, go DONE.
REQ-015 io_acknowledge sampled only in ACCESS; acknowledge in IDLE or DONE ignored.
REQ-016 Acknowledge in first ACCESS cycle accepted; minimum request-to-done latency 3 cycles (grant, ack, done).
REQ-017 DONE: pulse granted mN_done for exactly one cycle, mN_error=0 unless timed out; return to IDLE; io_bus_enable=0.
REQ-018 Ungranted master's done/error stay 0; its read_data unchanged.
REQ-019 mN_req dropped mid-transfer: transfer still completes, done still pulses.
REQ-020 Requester samples mN_req in IDLE only; a request held through DONE is re-arbitrated (one IDLE cycle minimum between transfers).
REQ-021 io_address/io_rw/io_byte_enable/io_write_data hold last values when idle.
REQ-022 last-grant pointer updates on each grant, including timed-out transfers.

Reset
REQ-023 reset_reset_n=0 asynchronously forces: state IDLE, io_bus_enable=0, io_address=0, io_byte_enable=0, io_rw=1, io_write_data=0, mN_done=0, mN_error=0, mN_read_data=0, last-grant=m1 (so m0 wins), timeout counter=0.
REQ-024 Reset mid-transfer aborts it; no done pulse issued; deassertion resumes from IDLE on next clock edge.

Configuration
REQ-025 Macro IO_BUS_ARBITER_TIMEOUT_EN defined: counter clears on ACCESS entry, increments each ACCESS cycle without acknowledge; reaching TIMEOUT_CYCLES -> deassert io_bus_enable, go DONE with mN_error=1, mN_read_data unchanged.
REQ-026 Macro undefined: no counter; ACCESS waits indefinitely; mN_error tied 0; TIMEOUT_CYCLES ignored.

Verification
REQ-027 m0 read 0x0040, slave acks 2 cycles after io_bus_enable with 0xBEEF -> m0_done one pulse, m0_read_data=0xBEEF, m0_error=0, m1 outputs unchanged.
REQ-028 m0 and m1 request same cycle after reset -> m0 granted first, m1 second; both held again -> m0, m1 alternate.
REQ-029 m1 write 0x1234 to 0x0010, byte_enable 2'b01 -> io_rw=0, io_write_data=0x1234, io_byte_enable=01 stable until ack; m1_done one cycle after ack.
REQ-030 Timeout build, TIMEOUT_CYCLES=8, no ack -> io_bus_enable high exactly 8 cycles, then m0_done=1 with m0_error=1.
REQ-031 reset_reset_n low during ACCESS -> io_bus_enable=0 immediately (same cycle), no done pulse; fresh request after release serviced normally.
REQ-032 Ack asserted while IDLE -> ignored, no done pulse, no state change.
